// File: rtl/sensor_uart_sched.sv
`default_nettype none
// ============================================================================
// Module      : sensor_uart_sched
// Description : Round-robin scheduler that serialises NUM_CH channel results
//               into ASCII text frames on a single UART byte stream.
//               Frame format: '<id>' ':' <DATA_W/4 uppercase hex> CR LF.
//
// Ports       : clk         - system clock, rising edge
//               reset_n     - asynchronous active-low reset
//               ch_valid_i  - per-channel result-pending request
//               ch_data_i   - channel results, channel k at [k*DATA_W +: DATA_W]
//               ch_ack_o    - one-cycle acknowledge, result latched
//               tx_data_o   - byte to UART transmitter
//               tx_valid_o  - tx_data_o valid
//               tx_ready_i  - transmitter accepts byte this cycle
//               busy_o      - high whenever a frame is being built/sent
//               grant_id_o  - channel being served (holds last when idle)
//
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_uart_sched #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        ch_valid_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    output logic [NUM_CH-1:0]        ch_ack_o,
    output logic [7:0]               tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic                     busy_o,
    output logic [2:0]               grant_id_o
);

    localparam int c_num_dig = DATA_W / 4;
    localparam int c_nib_w   = (c_num_dig > 1) ? $clog2(c_num_dig) : 1;
    localparam logic [c_nib_w-1:0] c_last_nib = c_nib_w'(c_num_dig - 1);
    localparam logic [2:0]         c_last_ch  = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SEND_ID  = 3'd2,
        S_SEND_SEP = 3'd3,
        S_SEND_HEX = 3'd4,
        S_SEND_CR  = 3'd5,
        S_SEND_LF  = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_rr_ptr;
    logic [2:0]           r_grant;
    logic [c_nib_w-1:0]   r_nib;
    logic [DATA_W-1:0]    r_data;

    logic                 w_req_any;
    logic [2:0]           w_grant;
    logic [DATA_W-1:0]    w_sel_data;
    logic [3:0]           w_nib;
    logic [7:0]           w_hex;

    // ------------------------------------------------------------------
    // Round-robin arbitration: the requester with the smallest cyclic
    // distance from rr_ptr wins.
    // ------------------------------------------------------------------
    always_comb begin
        int w_best;
        int w_dist;
        w_req_any = |ch_valid_i;
        w_grant   = r_rr_ptr;
        w_best    = NUM_CH;
        for (int k = 0; k < NUM_CH; k++) begin
            w_dist = (k - int'(r_rr_ptr) + NUM_CH) % NUM_CH;
            if (ch_valid_i[k] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_grant = 3'(k);
            end
        end
    end

    // Data select and acknowledge decode for the granted channel.
    always_comb begin
        w_sel_data = '0;
        ch_ack_o   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_grant == 3'(k)) begin
                w_sel_data  = ch_data_i[k*DATA_W +: DATA_W];
                ch_ack_o[k] = (r_state == S_LOAD);
            end
        end
    end

    // Current hex digit; nibble index r_nib selects bits [4*r_nib +: 4].
    always_comb begin
        w_nib = 4'(r_data >> {r_nib, 2'b00});
        w_hex = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                : (8'h37 + {4'h0, w_nib});
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state and byte-stream outputs. Outputs depend only on
    // registered state, so they stay stable while tx_ready_i is low.
    always_comb begin
        w_state_nxt = r_state;
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        busy_o      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_req_any) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = S_SEND_ID;
            end
            S_SEND_ID: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'h30 + {5'b0, r_grant};
                if (tx_ready_i) w_state_nxt = S_SEND_SEP;
            end
            S_SEND_SEP: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'h3A;
                if (tx_ready_i) w_state_nxt = S_SEND_HEX;
            end
            S_SEND_HEX: begin
                tx_valid_o = 1'b1;
                tx_data_o  = w_hex;
                if (tx_ready_i && (r_nib == '0)) w_state_nxt = S_SEND_CR;
            end
            S_SEND_CR: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'h0D;
                if (tx_ready_i) w_state_nxt = S_SEND_LF;
            end
            S_SEND_LF: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'h0A;
                if (tx_ready_i) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= 3'd0;
            r_grant  <= 3'd0;
            r_nib    <= '0;
            r_data   <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_req_any) begin
                r_grant <= w_grant;
            end
            // Result is frozen here; later ch_data_i changes cannot
            // affect the frame in flight.
            if (r_state == S_LOAD) begin
                r_data <= w_sel_data;
            end
            if ((r_state == S_SEND_SEP) && tx_ready_i) begin
                r_nib <= c_last_nib;
            end else if ((r_state == S_SEND_HEX) && tx_ready_i && (r_nib != '0)) begin
                r_nib <= r_nib - 1'b1;
            end
            if ((r_state == S_SEND_LF) && tx_ready_i) begin
                r_rr_ptr <= (r_grant == c_last_ch) ? 3'd0 : (r_grant + 3'd1);
            end
        end
    end

    assign grant_id_o = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_sensor_uart_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_uart_sched
// Description : Scoreboard bench for sensor_uart_sched. Stimulus pushes the
//               expected bytes/acks of each frame (computed from the frame
//               format and round-robin rule) into queues; an independent
//               monitor pops and compares on every byte transfer and ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_uart_sched;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 24;
    localparam int NDIG   = DATA_W / 4;

    logic                     clk;
    logic                     reset_n;
    logic [NUM_CH-1:0]        ch_valid_i;
    logic [NUM_CH*DATA_W-1:0] ch_data_i;
    logic [NUM_CH-1:0]        ch_ack_o;
    logic [7:0]               tx_data_o;
    logic                     tx_valid_o;
    logic                     tx_ready_i;
    logic                     busy_o;
    logic [2:0]               grant_id_o;

    sensor_uart_sched #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ch_valid_i (ch_valid_i),
        .ch_data_i  (ch_data_i),
        .ch_ack_o   (ch_ack_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .busy_o     (busy_o),
        .grant_id_o (grant_id_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    int          exp_ack[$];
    int          model_ptr = 0;
    logic [DATA_W-1:0] cur_data [NUM_CH];
    bit          rand_ready = 1'b0;
    int          xfer_cnt = 0;
    int          ack_cnt [NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic sample();
        @(negedge clk);
        #4;
    endtask

    task automatic set_data(input int c, input logic [DATA_W-1:0] v);
        cur_data[c] = v;
        ch_data_i[c*DATA_W +: DATA_W] = v;
    endtask

    // ---------------- reference model ----------------
    function automatic void push_frame(input int ch, input logic [DATA_W-1:0] d);
        int nib;
        exp_ack.push_back(ch);
        exp_q.push_back(8'(48 + ch));
        exp_q.push_back(8'h3A);
        for (int i = NDIG - 1; i >= 0; i--) begin
            nib = int'((d >> (4 * i)) & 'hF);
            exp_q.push_back((nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    function automatic int pick(input int mask);
        int c;
        for (int off = 0; off < NUM_CH; off++) begin
            c = (model_ptr + off) % NUM_CH;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    // Requests in mask are held until acked; each is served once in
    // round-robin order starting at the model pointer.
    function automatic void model_serve(input int mask);
        int m;
        int g;
        m = mask;
        while (m != 0) begin
            g = pick(m);
            push_frame(g, cur_data[g]);
            model_ptr = (g + 1) % NUM_CH;
            m = m & ~(1 << g);
        end
    endfunction

    // ---------------- ready driver ----------------
    initial begin
        tx_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            tx_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit         prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            sample();
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(tx_valid_o), 32'd1);
                    check("hold_data", 32'(tx_data_o), 32'(prev_data));
                end
                if (ch_ack_o != '0) begin
                    for (int c = 0; c < NUM_CH; c++) if (ch_ack_o[c]) ack_cnt[c]++;
                    if (exp_ack.size() == 0) begin
                        fail($sformatf("ack_unexpected got 0x%0h", ch_ack_o));
                    end else begin
                        check("ack", 32'(ch_ack_o), 32'(1 << exp_ack.pop_front()));
                    end
                end
                if (tx_valid_o && tx_ready_i) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        fail($sformatf("byte_unexpected got 0x%0h", tx_data_o));
                    end else begin
                        check("byte", 32'(tx_data_o), 32'(exp_q.pop_front()));
                    end
                end
                prev_stall = tx_valid_o && !tx_ready_i;
                prev_data  = tx_data_o;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        ch_valid_i = '0;
        exp_q.delete();
        exp_ack.delete();
        model_ptr = 0;
        #1;
        check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        check("rst_tx_data", 32'(tx_data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ack", 32'(ch_ack_o), 32'd0);
        check("rst_grant", 32'(grant_id_o), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((busy_o || exp_q.size() != 0 || ch_valid_i != '0) && k < 4000) begin
            sample();
            ch_valid_i = ch_valid_i & ~ch_ack_o;
            k++;
        end
        if (k >= 4000) fail({name, "_timeout"});
    endtask

    task automatic run_batch(input logic [NUM_CH-1:0] mask);
        for (int c = 0; c < NUM_CH; c++) if (mask[c]) set_data(c, DATA_W'($urandom));
        model_serve(int'(mask));
        @(negedge clk);
        ch_valid_i = mask;
        wait_drain("batch");
    endtask

    task automatic wait_ack(input int c);
        int k;
        k = 0;
        do begin
            sample();
            k++;
        end while (!ch_ack_o[c] && k < 200);
        if (k >= 200) fail("ack_wait_timeout");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acks;
        int k;
        int base;
        int c2_before;
        logic [DATA_W-1:0] d;

        reset_n    = 1'b0;
        ch_valid_i = '0;
        ch_data_i  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cur_data[c] = '0;
            ack_cnt[c]  = 0;
        end
        do_reset();

        // Single request with fixed latency checks.
        set_data(0, 24'h00ABCD);
        model_serve(1);
        @(negedge clk);
        ch_valid_i = 4'b0001;
        #4;
        check("c0_busy", 32'(busy_o), 32'd0);
        sample();
        check("c1_ack", 32'(ch_ack_o), 32'h1);
        check("c1_busy", 32'(busy_o), 32'd1);
        ch_valid_i = '0;
        for (int cyc = 2; cyc <= 12; cyc++) begin
            sample();
            if (cyc == 2) begin
                check("c2_valid", 32'(tx_valid_o), 32'd1);
                check("c2_id", 32'(tx_data_o), 32'h30);
            end
            if (cyc == 11) check("c11_lf", 32'(tx_data_o), 32'h0A);
            if (cyc == 12) check("c12_busy", 32'(busy_o), 32'd0);
        end

        // Round robin with all channels held for five frames.
        do_reset();
        for (int c = 0; c < NUM_CH; c++) set_data(c, DATA_W'($urandom));
        for (int f = 0; f < 5; f++) begin
            k = pick(4'hF);
            push_frame(k, cur_data[k]);
            model_ptr = (k + 1) % NUM_CH;
        end
        @(negedge clk);
        ch_valid_i = 4'hF;
        acks = 0;
        k = 0;
        while ((acks < 5 || busy_o || exp_q.size() != 0) && k < 4000) begin
            sample();
            if (ch_ack_o != '0) acks++;
            if (acks >= 5) ch_valid_i = '0;
            k++;
        end
        if (k >= 4000) fail("rr_timeout");

        // Backpressure on an all-F frame from channel 3.
        rand_ready = 1'b1;
        set_data(3, 24'hFFFFFF);
        model_serve(4'b1000);
        @(negedge clk);
        ch_valid_i = 4'b1000;
        wait_drain("bp");

        // Randomized batches under backpressure.
        for (int b = 0; b < 25; b++) run_batch(NUM_CH'($urandom_range(1, 15)));
        rand_ready = 1'b0;

        // Withdrawal: a one-cycle ch2 request while busy is never served.
        c2_before = ack_cnt[2];
        set_data(0, DATA_W'($urandom));
        model_serve(1);
        @(negedge clk);
        ch_valid_i = 4'b0001;
        wait_ack(0);
        ch_valid_i = '0;
        repeat (3) sample();
        ch_valid_i = 4'b0100;
        sample();
        ch_valid_i = '0;
        wait_drain("withdraw");
        repeat (5) sample();
        check("withdraw_no_ch2_ack", 32'(ack_cnt[2] - c2_before), 32'd0);

        // Data freeze: ch0 data changes during the hex digits.
        d = 24'h9E0C71;
        set_data(0, d);
        model_serve(1);
        @(negedge clk);
        ch_valid_i = 4'b0001;
        wait_ack(0);
        ch_valid_i = '0;
        repeat (4) sample();
        set_data(0, 24'h123456);
        wait_drain("freeze");

        // Reset in the middle of the hex digits.
        set_data(0, 24'h5A5A5A);
        model_serve(1);
        @(negedge clk);
        ch_valid_i = 4'b0001;
        wait_ack(0);
        ch_valid_i = '0;
        base = xfer_cnt;
        k = 0;
        while (xfer_cnt < base + 4 && k < 200) begin
            sample();
            k++;
        end
        if (k >= 200) fail("midreset_wait_timeout");
        do_reset();
        run_batch(4'b0010);
        run_batch(4'b1010);

        repeat (3) sample();
        check("exp_bytes_left", 32'(exp_q.size()), 32'd0);
        check("exp_acks_left", 32'(exp_ack.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(600000);
        $display("FAIL watchdog expired at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/sensor_uart_sched.md
SENSOR_UART_SCHED -- requirements
Module: sensor_uart_sched

Interface
REQ-001 SHALL have parameter: NUM_CH, 4, number of measurement channels sharing one UART byte transmitter (2..8).
REQ-002 SHALL have parameter: DATA_W, 24, width of each channel result; fixed multiple of 4.
REQ-003 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: ch_valid_i  input  NUM_CH  per-channel result-pending request.
REQ-006 SHALL have port: ch_data_i  input  NUM_CH*DATA_W  channel results; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port: ch_ack_o  output  NUM_CH  one-cycle acknowledge; result latched.
REQ-008 SHALL have port: tx_data_o  output  8  byte to UART transmitter.
REQ-009 SHALL have port: tx_valid_o  output  1  tx_data_o valid.
REQ-010 SHALL have port: tx_ready_i  input  1  transmitter accepts byte this cycle.
REQ-011 SHALL have port: busy_o  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port: grant_id_o  output  3  index of channel being served; holds last value when idle.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SEND_ID, SEND_SEP, SEND_HEX, SEND_CR, SEND_LF.
REQ-014 SHALL in IDLE, when any ch_valid_i is set, grant the lowest set index at or above rr_ptr, wrapping modulo NUM_CH, and go to LOAD next cycle.
REQ-015 SHALL in LOAD latch the granted channel's ch_data_i, pulse ch_ack_o[grant] high for exactly that one cycle, and go to SEND_ID.
REQ-016 SHALL sample ch_valid_i only in IDLE; a request dropped before grant is ignored without error; requests arriving while busy wait.
REQ-017 SHALL send a 10-byte frame: ASCII '0'+grant, ':' (0x3A), DATA_W/4 hex digits MSB nibble first, 0x0D, 0x0A.
REQ-018 SHALL encode nibble n as 0x30+n for n<10 and 0x41+(n-10) for n>=10 (uppercase).
REQ-019 SHALL treat a byte as transferred only on a clock edge where tx_valid_o and tx_ready_i are both high.
REQ-020 SHALL hold tx_valid_o and tx_data_o stable from assertion until transfer; no byte is dropped or repeated.
REQ-021 SHALL keep tx_valid_o high in every SEND_* state and low in IDLE and LOAD.
REQ-022 SHALL use a nibble counter in SEND_HEX running from DATA_W/4-1 down to 0, advancing once per transfer, and exit to SEND_CR after nibble 0 transfers.
REQ-023 SHALL on the LF transfer set rr_ptr to grant+1, wrapping NUM_CH-1 to 0, and return to IDLE.
REQ-024 SHALL reach IDLE after the LF transfer so a pending request is granted on that IDLE cycle; two back-to-back frames have exactly 2 idle-byte cycles (IDLE, LOAD).
REQ-025 SHALL give latency with tx_ready_i held high of: request seen in IDLE at cycle 0, ack at cycle 1, ID byte valid at cycle 2, and LF transferred at cycle 11.
REQ-026 SHALL be starvation-free: a continuously asserted request is served within NUM_CH frames.
REQ-027 SHALL not let ch_data_i changes after LOAD affect the frame in flight.

Reset
REQ-028 SHALL on reset_n low immediately set state=IDLE, rr_ptr=0, grant_id_o=0, ch_ack_o=0, tx_valid_o=0, tx_data_o=0x00, busy_o=0, nibble counter=0, and latched data=0.
REQ-029 SHALL on reset mid-frame abandon the partial frame; no resumption after release.
REQ-030 SHALL accept the first grant after reset release no earlier than the first rising edge with reset_n high.

Verification
REQ-031 SHALL verify single request: ch_valid_i=0001, ch0 data=0x00ABCD, tx_ready_i=1 -> bytes 30 3A 30 30 41 42 43 44 0D 0A; ack at cycle 1; busy_o low at cycle 12.
REQ-032 SHALL verify round-robin: all four valid continuously -> frames served ch0,ch1,ch2,ch3,ch0; each ack is one cycle.
REQ-033 SHALL verify backpressure: tx_ready_i toggles 1/0 pseudo-randomly, data=0xFFFFFF -> identical byte sequence 33 3A 46x6 0D 0A for ch3; tx_data_o stable while stalled.
REQ-034 SHALL verify withdrawal: ch2 valid for 1 cycle while busy, then low -> no ch2 ack, no ch2 frame.
REQ-035 SHALL verify reset mid-hex: assert reset_n low after 4th byte -> all outputs at reset values same cycle; after release, ch1 request -> frame starts with 0x31 and rr_ptr behaves as from 0.
REQ-036 SHALL verify data freeze: change ch0 data to 0x123456 during SEND_HEX -> frame shows the value latched at LOAD.
